prim_gf_hash_acc: RTL and testbench

- Polynomial-hash accumulator that drives a GF(2^Width) multiplier and consumes its product. The multiplier is instantiated alongside this block, not inside it.
- Computes the Horner/GHASH-style chain Y_i = (Y_{i-1} XOR X_i) * H over a message of Width-bit blocks. Y_0 = 0 and H is the key latched at message start.
- Sits between a block-stream source (valid/ready) and a digest sink. Works unchanged with full-combinational or digit-serial multiplier configurations.

---
 rtl/prim_gf_hash_acc.sv | 109 ++++++++++
 tb/tb_prim_gf_hash_acc.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prim_gf_hash_acc.sv
// Polynomial-hash accumulator: Y_i = (Y_{i-1} ^ X_i) * H using an
// external GF(2^Width) multiplier over a req/ack operand interface.
module prim_gf_hash_acc #(
  parameter int unsigned Width    = 32,
  parameter int unsigned CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [Width-1:0]    key_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [Width-1:0]    in_data_i,
  input  logic                in_last_i,
  output logic                mult_req_o,
  output logic [Width-1:0]    mult_a_o,
  output logic [Width-1:0]    mult_b_o,
  input  logic                mult_ack_i,
  input  logic [Width-1:0]    mult_prod_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [Width-1:0]    out_digest_o,
  output logic [CntWidth-1:0] out_blocks_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StOut  = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [Width-1:0]    acc_q, acc_d;
  logic [Width-1:0]    opa_q, opa_d;
  logic [Width-1:0]    key_q, key_d;
  logic                last_q, last_d;
  logic                first_q, first_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;

  logic accept;
  assign accept = in_valid_i & in_ready_o;

  // Next-state and datapath update for the accept/multiply/emit loop.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    opa_d   = opa_q;
    key_d   = key_q;
    last_d  = last_q;
    first_d = first_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          opa_d   = (first_q ? '0 : acc_q) ^ in_data_i;
          last_d  = in_last_i;
          state_d = StMul;
          if (first_q) begin
            key_d   = key_i;
            first_d = 1'b0;
          end
        end
      end
      StMul: begin
        if (mult_ack_i) begin
          acc_d   = mult_prod_i;
          cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
          state_d = last_q ? StOut : StIdle;
        end
      end
      StOut: begin
        if (out_ready_i) begin
          acc_d   = '0;
          cnt_d   = '0;
          first_d = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset discards any partial message.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      acc_q   <= '0;
      opa_q   <= '0;
      key_q   <= '0;
      last_q  <= 1'b0;
      first_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opa_q   <= opa_d;
      key_q   <= key_d;
      last_q  <= last_d;
      first_q <= first_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready_o   = (state_q == StIdle);
  assign mult_req_o   = (state_q == StMul);
  assign mult_a_o     = mult_req_o ? opa_q : '0;
  assign mult_b_o     = mult_req_o ? key_q : '0;
  assign out_valid_o  = (state_q == StOut);
  assign out_digest_o = out_valid_o ? acc_q : '0;
  assign out_blocks_o = out_valid_o ? cnt_q : '0;

endmodule

// File: tb/tb_prim_gf_hash_acc.sv
// Scoreboard bench for prim_gf_hash_acc with a behavioural
// GF(2^32) multiplier of configurable latency attached.
module tb_prim_gf_hash_acc;

  localparam int CW = 4;
  localparam logic [31:0] POLY = 32'h0000_8299;

  logic          clk = 0;
  logic          rst_i = 1;
  logic [31:0]   key_i = 0;
  logic          in_valid_i = 0;
  logic          in_ready_o;
  logic [31:0]   in_data_i = 0;
  logic          in_last_i = 0;
  logic          mult_req_o;
  logic [31:0]   mult_a_o, mult_b_o;
  logic          mult_ack_i;
  logic [31:0]   mult_prod_i;
  logic          out_valid_o;
  logic          out_ready_i = 1;
  logic [31:0]   out_digest_o;
  logic [CW-1:0] out_blocks_o;

  prim_gf_hash_acc #(.Width(32), .CntWidth(CW)) dut (
    .clk_i(clk), .rst_i(rst_i), .key_i(key_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_data_i(in_data_i), .in_last_i(in_last_i),
    .mult_req_o(mult_req_o), .mult_a_o(mult_a_o),
    .mult_b_o(mult_b_o), .mult_ack_i(mult_ack_i),
    .mult_prod_i(mult_prod_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_digest_o(out_digest_o),
    .out_blocks_o(out_blocks_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    int          n;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total = 0;
  int   cyc = 0;
  int   loops = 1;
  int   mcnt;
  int   reqrun = 0;
  logic [31:0] a0, b0;

  function automatic logic [31:0] gf_mul(input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] r;
    logic [31:0] x;
    r = 0;
    x = a;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) r = r ^ x;
      x = x[31] ? ((x << 1) ^ POLY) : (x << 1);
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_digest(input logic [31:0] key,
                                             input logic [31:0] blks[$]);
    logic [31:0] y;
    y = 0;
    foreach (blks[i]) y = gf_mul(y ^ blks[i], key);
    return y;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: product after 'loops' request cycles; junk when idle.
  always @(posedge clk or posedge rst_i) begin
    if (rst_i) mcnt <= 0;
    else if (mult_req_o) mcnt <= mult_ack_i ? 0 : mcnt + 1;
  end

  always_comb begin
    mult_ack_i  = cyc[0];
    mult_prod_i = 32'hDEAD_BEEF ^ 32'(cyc);
    if (mult_req_o) begin
      mult_ack_i  = (mcnt == loops - 1);
      mult_prod_i = gf_mul(mult_a_o, mult_b_o);
    end
  end

  // Monitor: request length, operand stability, digest scoreboard.
  always @(negedge clk) begin
    if (rst_i) begin
      reqrun = 0;
    end else begin
      if (mult_req_o) begin
        if (reqrun == 0) begin
          a0 = mult_a_o;
          b0 = mult_b_o;
        end else begin
          chk("opnd_stable", {mult_a_o, mult_b_o}, {a0, b0});
        end
        reqrun++;
      end else begin
        if (reqrun != 0) chk("req_len", 64'(reqrun), 64'(loops));
        reqrun = 0;
        chk("opnd_idle_zero", {mult_a_o, mult_b_o}, 64'd0);
      end
      if (out_valid_o && out_ready_i) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_out", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("digest", 64'(out_digest_o), 64'(e.d));
          chk("blocks", 64'(out_blocks_o), 64'(e.n));
        end
      end
    end
  end

  task automatic wait_accept(output bit ok);
    ok = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (in_ready_o) begin
        @(posedge clk);
        #1;
        ok = 1;
        return;
      end
    end
    chk("accept_timeout", 64'd1, 64'd0);
  endtask

  task automatic send_msg(input logic [31:0] key, input logic [31:0] blks[$],
                          input bit hold, input bit push);
    exp_t e;
    bit   ok;
    int   prev;
    prev = 0;
    if (push) begin
      e.d = ref_digest(key, blks);
      e.n = blks.size() > 15 ? 15 : blks.size();
      sb.push_back(e);
    end
    foreach (blks[i]) begin
      in_valid_i = 1;
      in_data_i  = blks[i];
      in_last_i  = (i == blks.size() - 1);
      key_i      = (i == 0) ? key : $urandom;
      wait_accept(ok);
      if (!ok) return;
      if (hold && i > 0) chk("accept_gap", 64'(cyc - prev), 64'(loops + 1));
      prev = cyc;
      if (!hold || in_last_i) begin
        in_valid_i = 0;
        if (!hold) repeat ($urandom % 2) @(posedge clk);
        #1;
      end
    end
    in_valid_i = 0;
  endtask

  task automatic drain(input bit bp);
    for (int k = 0; k < 800; k++) begin
      if (sb.size() == 0 && in_ready_o) begin
        out_ready_i = 1;
        return;
      end
      out_ready_i = bp ? 1'($urandom % 2) : 1'b1;
      @(posedge clk);
      #1;
    end
    out_ready_i = 1;
    chk("drain_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] e;
    bit          ok;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(in_ready_o), 64'd1);
    chk("rst_req_valid", {62'd0, mult_req_o, out_valid_o}, 64'd0);
    chk("rst_out", {28'd0, out_blocks_o, out_digest_o}, 64'd0);
    rst_i = 0;
    @(posedge clk);
    #1;

    loops = 1;
    q = '{32'h8000_0000};
    send_msg(32'h2, q, 0, 1);
    chk("valid_before_ack", 64'(out_valid_o), 64'd0);
    @(posedge clk);
    #1;
    chk("valid_after_ack", 64'(out_valid_o), 64'd1);
    chk("t1_digest", 64'(out_digest_o), 64'h8299);
    drain(0);

    q = '{32'h1234_5678, 32'h0F0F_0F0F};
    chk("ref_t2", 64'(ref_digest(32'h1, q)), 64'h1D3B_5977);
    send_msg(32'h1, q, 0, 1);
    drain(0);

    q = '{32'h1, 32'h0};
    repeat (2) begin
      send_msg(32'h2, q, 0, 1);
      drain(0);
    end

    loops = 4;
    q = '{$urandom, $urandom, $urandom};
    send_msg($urandom, q, 1, 1);
    drain(0);

    out_ready_i = 0;
    q = '{$urandom};
    send_msg(32'h3, q, 0, 1);
    e = ref_digest(32'h3, q);
    for (int k = 0; k < 50 && !out_valid_o; k++) @(negedge clk);
    repeat (10) begin
      @(negedge clk);
      chk("hold_valid", 64'(out_valid_o), 64'd1);
      chk("hold_digest", 64'(out_digest_o), 64'(e));
      chk("hold_blocks", 64'(out_blocks_o), 64'd1);
      chk("hold_ready", 64'(in_ready_o), 64'd0);
    end
    @(posedge clk);
    #1;
    out_ready_i = 1;
    @(posedge clk);
    #1;
    out_ready_i = 0;
    chk("pulse_idle", {62'd0, in_ready_o, out_valid_o}, 64'd2);
    out_ready_i = 1;
    drain(0);

    in_valid_i = 1;
    key_i      = 32'h2;
    in_data_i  = 32'h8000_0000;
    in_last_i  = 1;
    wait_accept(ok);
    in_valid_i = 0;
    @(posedge clk);
    #1;
    chk("pre_rst_req", 64'(mult_req_o), 64'd1);
    rst_i = 1;
    #1;
    chk("mid_rst_ready", 64'(in_ready_o), 64'd1);
    chk("mid_rst_req_valid", {62'd0, mult_req_o, out_valid_o}, 64'd0);
    chk("mid_rst_opnd", {mult_a_o, mult_b_o}, 64'd0);
    chk("mid_rst_out", {28'd0, out_blocks_o, out_digest_o}, 64'd0);
    @(posedge clk);
    #1;
    rst_i = 0;
    q = '{32'h8000_0000};
    send_msg(32'h2, q, 0, 1);
    drain(0);

    loops = 1;
    q = {};
    for (int i = 0; i < 18; i++) q.push_back($urandom);
    send_msg($urandom, q, 0, 1);
    drain(1);

    for (int m = 0; m < 20; m++) begin
      loops = 1 << ($urandom % 4);
      q = {};
      for (int i = 0; i < 1 + int'($urandom % 6); i++) q.push_back($urandom);
      send_msg($urandom, q, 1'($urandom % 2), 1);
      drain(1);
    end

    chk("sb_empty_end", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
